nerv_buttons: RTL and testbench
===============================

# nerv_buttons

Memory-mapped push-button input peripheral for nervsoc: the input-side counterpart of the LED output register. It synchronizes and debounces up to 8 board buttons, exposes their stable levels, and latches press/release events into sticky write-1-to-clear registers. It also raises a level interrupt for enabled press events. It sits on the SoC's simple peripheral bus next to the LED register; the board top wires raw button pins to `btn_in`.

## Interface
- `NUM_BTNS`, 3: number of buttons, 1..8.
- `DEBOUNCE_CYCLES`, 120000: consecutive disagreeing cycles required to accept a level change (10 ms at 12 MHz); must be ≥1.
- `BTN_INVERT`, 0: per-button mask; a set bit means that pin is active-low and is inverted before synchronization.
- `clock` input 1: single clock for all logic.
- `resetn` input 1: asynchronous, active-low reset.
- `btn_in` input NUM_BTNS: raw, asynchronous button pins.
- `bus_valid` input 1: request, held until `bus_ready`.
- `bus_write` input 1: 1 = write, 0 = read; stable while `bus_valid`.
- `bus_addr` input 2: word index (0 STATE, 1 PRESSED, 2 RELEASED, 3 IRQ_EN).
- `bus_wdata` input 32: write data.
- `bus_rdata` output 32: read data, valid while `bus_ready`.
- `bus_ready` output 1: one-cycle completion pulse.
- `irq` output 1: level interrupt, `|(PRESSED & IRQ_EN)`.

## Operation
- Input path, per button: `b = btn_in ^ BTN_INVERT`, then two flip-flops `s1 -> s2`. `s2` is the synchronized level.
- Debounce, per button: counter width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When `s2 == stable`, the counter clears to 0.
  - Otherwise it increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, `stable <= s2` and the counter clears.
  - Any single cycle of agreement restarts the count.
- Events: a `stable` 0→1 transition sets PRESSED[i]; a 1→0 transition sets RELEASED[i].
- Registers:
  - STATE (read-only): `stable`. Writes are ignored.
  - PRESSED and RELEASED: sticky. Writing 1 clears a bit; writing 0 has no effect.
  - IRQ_EN: read/write, width NUM_BTNS.
  - Bits ≥NUM_BTNS read 0 and ignore writes.
- Reads have no side effects; reading PRESSED does not clear it.
- Simultaneous clear and new event on the same bit in the same cycle: the set wins, the bit stays 1.
- Bus handshake: `bus_ready <= bus_valid & ~bus_ready`.
  - A write updates its target on the same edge that raises `bus_ready`.
  - A read registers `bus_rdata` on that same edge.
  - `bus_rdata` holds its value until the next read.
  - If a master holds `bus_valid` continuously, it gets one completion every 2 cycles.
- Reset values (asynchronous): `s1`, `s2`, `stable`, counters, PRESSED, RELEASED, IRQ_EN, `bus_ready`, and `bus_rdata` are all 0; `irq` is 0.
  - Buttons held at reset are seen as a press after debounce.
  - Reset asserted mid-debounce discards the partial count.
  - Reset asserted mid-transaction drops the transaction with no `bus_ready` pulse.

## Timing
- Pin-to-STATE latency: 2 cycles of synchronization plus DEBOUNCE_CYCLES cycles.
  - If `btn_in` changes before edge 0 and stays stable, `s2` changes at edge 1.
  - `stable` and PRESSED/RELEASED update at edge 1+DEBOUNCE_CYCLES.
- `irq` is registered: it updates one edge after PRESSED or IRQ_EN changes.
- Bus: `bus_ready` rises at the edge after `bus_valid` is first sampled, giving 1-cycle latency for both read and write.
- A W1C write and a read of the same register back-to-back: the read returns the post-clear value.
- All outputs are registered; there is no combinational path from `btn_in` or the bus inputs to any output.

## Test plan
- Reset: with `btn_in=0`, deassert `resetn`, then read all 4 registers -> every read returns 0, `irq=0`, `bus_ready` pulses exactly 1 cycle per read.
- Clean press (DEBOUNCE_CYCLES=4): set `btn_in[0]=1` and hold -> STATE=0x1 and PRESSED=0x1 exactly 5 edges after the change; RELEASED=0.
- Bounce rejection (DEBOUNCE_CYCLES=4): toggle `btn_in[1]` with high pulses of 3 cycles and low gaps of 1 cycle, for 40 cycles -> STATE[1] stays 0 and PRESSED=0.
- W1C race: with PRESSED=0x1, write 0x1 to PRESSED on the same edge button 0 completes a new press -> PRESSED still reads 0x1; a second write of 0x1 -> reads 0x0.
- Interrupt: IRQ_EN=0x4, press button 2 -> `irq=1` one edge after PRESSED[2] sets; write 0x4 to PRESSED -> `irq=0` one edge later; pressing button 0 leaves `irq=0`.
- Inversion and async reset: with BTN_INVERT=0x1 and `btn_in[0]=0` held, STATE[0]=1 after debounce; pulse `resetn` low mid-debounce on button 1 -> all registers 0 immediately, and button 0 re-debounces to STATE=0x1.

Source files
------------

// File: rtl/nerv_buttons.sv
// Push-button peripheral: synchronizes and debounces up to 8 buttons and latches
// press/release events into sticky write-1-to-clear registers with a press interrupt.
module nerv_buttons #(
  parameter int                  NUM_BTNS        = 3,
  parameter int                  DEBOUNCE_CYCLES = 120000,
  parameter logic [NUM_BTNS-1:0] BTN_INVERT      = '0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_BTNS-1:0] btn_in,
  input  logic                bus_valid,
  input  logic                bus_write,
  input  logic [1:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_ready,
  output logic                irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATE    = 2'd0;
  localparam logic [1:0] ADDR_PRESSED  = 2'd1;
  localparam logic [1:0] ADDR_RELEASED = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN   = 2'd3;

  logic [NUM_BTNS-1:0] s1;
  logic [NUM_BTNS-1:0] s2;
  logic [NUM_BTNS-1:0] stable;
  logic [NUM_BTNS-1:0] pressed;
  logic [NUM_BTNS-1:0] released;
  logic [NUM_BTNS-1:0] irq_en;
  logic [NUM_BTNS-1:0] accept;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] fall;
  logic [NUM_BTNS-1:0] clr_pressed;
  logic [NUM_BTNS-1:0] clr_released;
  logic [CW-1:0]       cnt [NUM_BTNS];
  logic                access;
  logic                wr_access;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^bus_wdata[31:NUM_BTNS];

  // A button is accepted on the edge its counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = accept & s2;
  assign fall = accept & ~s2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= btn_in ^ BTN_INVERT;
      s2 <= s1;
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign access    = bus_valid & ~bus_ready;
  assign wr_access = access & bus_write;

  always_comb begin
    clr_pressed  = '0;
    clr_released = '0;
    if (wr_access && bus_addr == ADDR_PRESSED) begin
      clr_pressed = bus_wdata[NUM_BTNS-1:0];
    end
    if (wr_access && bus_addr == ADDR_RELEASED) begin
      clr_released = bus_wdata[NUM_BTNS-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_STATE:    rd_mux[NUM_BTNS-1:0] = stable;
      ADDR_PRESSED:  rd_mux[NUM_BTNS-1:0] = pressed;
      ADDR_RELEASED: rd_mux[NUM_BTNS-1:0] = released;
      default:       rd_mux[NUM_BTNS-1:0] = irq_en;
    endcase
  end

  // New events are OR-ed in after the clear so a coincident event survives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pressed   <= '0;
      released  <= '0;
      irq_en    <= '0;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      pressed   <= (pressed & ~clr_pressed) | rise;
      released  <= (released & ~clr_released) | fall;
      bus_ready <= access;
      irq       <= |(pressed & irq_en);
      if (wr_access && bus_addr == ADDR_IRQ_EN) begin
        irq_en <= bus_wdata[NUM_BTNS-1:0];
      end
      if (access && !bus_write) begin
        bus_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_nerv_buttons.sv
// Directed self-checking bench for nerv_buttons: a register-access vector table
// plus hand-timed sequences for debounce, W1C race, interrupt and reset cases.
module tb_nerv_buttons;

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  btn_in;
  logic [2:0]  btn_inv;
  logic        bus_valid;
  logic        bus_write;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] bus_rdata_inv;
  logic        bus_ready;
  logic        bus_ready_inv;
  logic        irq;
  logic        irq_inv;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic [31:0] rd_inv;
  logic        irq_at_edge;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  always #5 clock = ~clock;

  nerv_buttons #(
    .NUM_BTNS(3), .DEBOUNCE_CYCLES(4), .BTN_INVERT(3'b000)
  ) dut (
    .clock(clock), .resetn(resetn), .btn_in(btn_in),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .irq(irq)
  );

  // Second copy shares the bus but has button 0 wired active-low.
  nerv_buttons #(
    .NUM_BTNS(3), .DEBOUNCE_CYCLES(4), .BTN_INVERT(3'b001)
  ) dut_inv (
    .clock(clock), .resetn(resetn), .btn_in(btn_inv),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata_inv), .bus_ready(bus_ready_inv),
    .irq(irq_inv)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One bus transaction: access lands on the next edge, then valid drops.
  task automatic apply_stimulus(input logic wr, input logic [1:0] addr,
                                input logic [31:0] wdata);
    bus_valid = 1'b1;
    bus_write = wr;
    bus_addr  = addr;
    bus_wdata = wdata;
    step(1);
    check_output("ready_rise", {31'b0, bus_ready}, 32'd1);
    rd          = bus_rdata;
    rd_inv      = bus_rdata_inv;
    irq_at_edge = irq;
    bus_valid = 1'b0;
    bus_write = 1'b0;
    step(1);
    check_output("ready_pulse", {31'b0, bus_ready}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        32'h7};
    vecs[6]  = '{1'b1, 2'd0, 32'hFF,       32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 2'd1, 32'hFF,       32'h0};
    vecs[9]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 2'd3, 32'h5,        32'h0};
    vecs[11] = '{1'b0, 2'd3, 32'h0,        32'h5};
    vecs[12] = '{1'b1, 2'd3, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 2'd3, 32'h0,        32'h0};

    resetn    = 1'b0;
    btn_in    = 3'b000;
    btn_inv   = 3'b001;
    bus_valid = 1'b0;
    bus_write = 1'b0;
    bus_addr  = 2'd0;
    bus_wdata = 32'h0;
    step(2);
    resetn = 1'b1;
    check_output("reset_irq", {31'b0, irq}, 32'd0);
    check_output("reset_ready", {31'b0, bus_ready}, 32'd0);
    check_output("reset_rdata", bus_rdata, 32'h0);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].wr) begin
        check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
      check_output($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'd0);
    end

    // Clean press: stable/PRESSED at the 6th edge after the pin change, irq one later.
    apply_stimulus(1'b1, 2'd3, 32'h1);
    btn_in[0] = 1'b1;
    step(6);
    check_output("press_irq_early", {31'b0, irq}, 32'd0);
    step(1);
    check_output("press_irq", {31'b0, irq}, 32'd1);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("press_state", rd, 32'h1);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("press_pressed", rd, 32'h1);
    apply_stimulus(1'b0, 2'd2, 32'h0);
    check_output("press_released", rd, 32'h0);

    btn_in[0] = 1'b0;
    step(8);
    apply_stimulus(1'b0, 2'd2, 32'h0);
    check_output("release_released", rd, 32'h1);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("release_state", rd, 32'h0);
    apply_stimulus(1'b1, 2'd2, 32'h1);
    apply_stimulus(1'b0, 2'd2, 32'h0);
    check_output("released_w1c", rd, 32'h0);

    // Bounce: 3-cycle highs with 1-cycle gaps never reach the threshold.
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = 1'b1;
      step(3);
      btn_in[1] = 1'b0;
      step(1);
    end
    step(4);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("bounce_state", rd, 32'h0);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("bounce_pressed", rd, 32'h1);

    // W1C race: clear of PRESSED[0] lands on the edge a new press is accepted.
    btn_in[0] = 1'b1;
    step(5);
    apply_stimulus(1'b1, 2'd1, 32'h1);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("race_pressed", rd, 32'h1);
    apply_stimulus(1'b1, 2'd1, 32'h1);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("race_cleared", rd, 32'h0);

    apply_stimulus(1'b1, 2'd3, 32'h4);
    btn_in[2] = 1'b1;
    step(6);
    check_output("irq2_early", {31'b0, irq}, 32'd0);
    step(1);
    check_output("irq2_set", {31'b0, irq}, 32'd1);
    apply_stimulus(1'b1, 2'd1, 32'h4);
    check_output("irq2_at_clear_edge", {31'b0, irq_at_edge}, 32'd1);
    check_output("irq2_cleared", {31'b0, irq}, 32'd0);
    btn_in[0] = 1'b0;
    step(8);
    btn_in[0] = 1'b1;
    step(8);
    check_output("irq_masked_btn0", {31'b0, irq}, 32'd0);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("masked_pressed", rd, 32'h1);

    // Inversion: active-low button 0 pressed by driving its pin low.
    btn_inv[0] = 1'b0;
    step(8);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("inv_state", rd_inv, 32'h1);
    check_output("noninv_state", rd, 32'h5);
    apply_stimulus(1'b1, 2'd3, 32'h7);
    check_output("irq_enabled_all", {31'b0, irq}, 32'd1);

    btn_in[1]  = 1'b1;
    btn_inv[1] = 1'b1;
    step(3);
    resetn = 1'b0;
    #1;
    check_output("async_rst_irq", {31'b0, irq}, 32'd0);
    check_output("async_rst_rdata", bus_rdata, 32'h0);
    check_output("async_rst_rdata_inv", bus_rdata_inv, 32'h0);
    btn_in[1]  = 1'b0;
    btn_inv[1] = 1'b0;
    step(2);
    resetn = 1'b1;
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("post_rst_state", rd, 32'h0);
    check_output("post_rst_state_inv", rd_inv, 32'h0);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("post_rst_pressed", rd, 32'h0);
    apply_stimulus(1'b0, 2'd3, 32'h0);
    check_output("post_rst_irq_en", rd, 32'h0);
    step(8);
    apply_stimulus(1'b0, 2'd0, 32'h0);
    check_output("redebounce_state", rd, 32'h5);
    check_output("redebounce_state_inv", rd_inv, 32'h1);
    apply_stimulus(1'b0, 2'd1, 32'h0);
    check_output("redebounce_pressed_inv", rd_inv, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
